demux8_deserializer: RTL and testbench

//  1-to-8 sequenced demultiplexer: inverse of the 8:1 select mux.

---
 rtl/demux8_deserializer.sv | 127 ++++++++++++
 tb/tb_demux8_deserializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux8_deserializer.sv
// Sequenced 1-to-LANES demultiplexer: rebuilds a framed serial stream into a
// parallel lane vector and offers it with a valid/ready handshake.
module demux8_deserializer #(
  parameter int LANES = 8,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic             in_ready,
  output logic [LANES-1:0] out_lanes,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             frame_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state_reg;
  logic [SEL_W-1:0] sel_reg;
  logic [LANES-1:0] lanes_reg;
  logic [LANES-1:0] lanes_next;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             frame_err_reg;

  logic accept;
  logic frame_start;
  logic lane_write;

  // in_ready_reg is low only in HOLD, so accept already excludes that state
  assign accept      = in_valid & in_ready_reg;
  assign frame_start = accept & in_sync;
  assign lane_write  = accept & ~in_sync & (state_reg == COLLECT);

  // Per-lane next value: a frame start loads lane 0 and clears the rest;
  // otherwise only the lane addressed by sel may change.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      if (gi == 0) begin : g_first
        assign lanes_next[gi] = frame_start ? in_bit :
                                (lane_write && sel_reg == SEL_W'(gi)) ? in_bit :
                                lanes_reg[gi];
      end else begin : g_rest
        assign lanes_next[gi] = frame_start ? 1'b0 :
                                (lane_write && sel_reg == SEL_W'(gi)) ? in_bit :
                                lanes_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_reg <= '0;
    end else begin
      lanes_reg <= lanes_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (in_sync) begin
              sel_reg   <= SEL_W'(1);
              state_reg <= COLLECT;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            if (in_sync) begin
              frame_err_reg <= 1'b1;
              sel_reg       <= SEL_W'(1);
            end else begin
              // LANES is a power of two, so the increment wraps to 0 on the last lane
              sel_reg <= sel_reg + SEL_W'(1);
              if (sel_reg == SEL_W'(LANES - 1)) begin
                state_reg     <= HOLD;
                in_ready_reg  <= 1'b0;
                out_valid_reg <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          sel_reg       <= '0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_lanes = lanes_reg;
  assign out_valid = out_valid_reg;
  assign sel       = sel_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_demux8_deserializer.sv
// Self-checking bench for demux8_deserializer: vector table, directed corner
// sequences and randomized traffic against a queue-based frame model.
module tb_demux8_deserializer;
  localparam int LANES = 8;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_bit;
  logic             in_valid;
  logic             in_sync;
  logic             in_ready;
  logic [LANES-1:0] out_lanes;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] sel;
  logic             frame_err;

  demux8_deserializer #(.LANES(LANES), .SEL_W(SEL_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .in_sync  (in_sync),
    .in_ready (in_ready),
    .out_lanes(out_lanes),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sel      (sel),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bits of the frame in progress, the last completed/kept word,
  // and whether a finished word is waiting for the consumer.
  bit               mq[$];
  bit               m_holding = 1'b0;
  logic [LANES-1:0] m_word = '0;
  bit               m_err = 1'b0;

  typedef struct packed {
    logic             b;
    logic             v;
    logic             s;
    logic             r;
    logic [LANES-1:0] lanes;
    logic             valid;
    logic [SEL_W-1:0] sel;
    logic             err;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [LANES-1:0] pack_frame();
    logic [LANES-1:0] w = '0;
    foreach (mq[i]) w[i] = mq[i];
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic b, input logic v, input logic s, input logic r, input logic rs);
    m_err = 1'b0;
    if (rs) begin
      mq.delete();
      m_holding = 1'b0;
      m_word    = '0;
    end else if (m_holding) begin
      if (r) begin
        $display("frame received lanes=%02h", m_word);
        m_holding = 1'b0;
      end
    end else if (v) begin
      if (s) begin
        m_err = (mq.size() != 0);
        mq.delete();
        mq.push_back(b);
      end else if (mq.size() == 0) begin
        m_err = 1'b1;
      end else begin
        mq.push_back(b);
      end
      if (mq.size() == LANES) begin
        m_word    = pack_frame();
        m_holding = 1'b1;
        mq.delete();
      end
    end
  endtask

  task automatic step(input logic b, input logic v, input logic s, input logic r,
                      input logic rs = 1'b0);
    logic [LANES-1:0] exp_lanes;
    in_bit = b; in_valid = v; in_sync = s; out_ready = r; rst = rs;
    @(posedge clk);
    model_edge(b, v, s, r, rs);
    #1;
    exp_lanes = (m_holding || mq.size() == 0) ? m_word : pack_frame();
    chk("out_lanes", 32'(out_lanes), 32'(exp_lanes));
    chk("out_valid", 32'(out_valid), 32'(m_holding));
    chk("in_ready",  32'(in_ready),  32'(!m_holding));
    chk("sel",       32'(sel),       32'(mq.size()));
    chk("frame_err", 32'(frame_err), 32'(m_err));
  endtask

  task automatic send_frame(input logic [7:0] w, input bit gaps, input logic r);
    for (int i = 0; i < LANES; i++) begin
      step(w[i], 1'b1, i == 0, r);
      if (gaps && i != LANES - 1) begin
        step(1'($urandom), 1'b0, 1'($urandom), r);
        chk("gap_sel", 32'(sel), 32'(i + 1));
      end
    end
  endtask

  initial begin
    // frame 1,0,1,1,0,0,1,0 with out_ready high, then one idle cycle
    tbl[0] = {1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 3'd1, 1'b0};
    tbl[1] = {1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 3'd2, 1'b0};
    tbl[2] = {1'b1, 1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 3'd3, 1'b0};
    tbl[3] = {1'b1, 1'b1, 1'b0, 1'b1, 8'h0D, 1'b0, 3'd4, 1'b0};
    tbl[4] = {1'b0, 1'b1, 1'b0, 1'b1, 8'h0D, 1'b0, 3'd5, 1'b0};
    tbl[5] = {1'b0, 1'b1, 1'b0, 1'b1, 8'h0D, 1'b0, 3'd6, 1'b0};
    tbl[6] = {1'b1, 1'b1, 1'b0, 1'b1, 8'h4D, 1'b0, 3'd7, 1'b0};
    tbl[7] = {1'b0, 1'b1, 1'b0, 1'b1, 8'h4D, 1'b1, 3'd0, 1'b0};
    tbl[8] = {1'b0, 1'b0, 1'b0, 1'b1, 8'h4D, 1'b0, 3'd0, 1'b0};

    in_bit = 1'b0; in_valid = 1'b0; in_sync = 1'b0; out_ready = 1'b0; rst = 1'b1;

    // reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_lanes", 32'(out_lanes), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ready", 32'(in_ready),  32'h1);
    chk("rst_sel",   32'(sel),       32'h0);

    // test 1: table-driven frame 8'h4D
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].b, tbl[i].v, tbl[i].s, tbl[i].r);
      chk("tbl_lanes", 32'(out_lanes), 32'(tbl[i].lanes));
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].valid));
      chk("tbl_sel",   32'(sel),       32'(tbl[i].sel));
      chk("tbl_err",   32'(frame_err), 32'(tbl[i].err));
    end

    // test 2: consumer stalls for 5 cycles; input activity is ignored
    send_frame(8'h4D, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("hold_valid", 32'(out_valid), 32'h1);
      chk("hold_ready", 32'(in_ready),  32'h0);
      chk("hold_lanes", 32'(out_lanes), 32'h4D);
      chk("hold_err",   32'(frame_err), 32'h0);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("release_valid", 32'(out_valid), 32'h0);
    chk("release_lanes", 32'(out_lanes), 32'h4D);

    // test 3: restart after 3 bits, then an all-ones frame
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("restart_err", 32'(frame_err), 32'h1);
    chk("restart_sel", 32'(sel),       32'h1);
    chk("restart_lanes", 32'(out_lanes), 32'h01);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("restart_word",  32'(out_lanes), 32'hFF);
    chk("restart_valid", 32'(out_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // test 4: unframed bit in IDLE
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("idle_err",   32'(frame_err), 32'h1);
    chk("idle_sel",   32'(sel),       32'h0);
    chk("idle_valid", 32'(out_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("idle_err_pulse", 32'(frame_err), 32'h0);

    // test 5: reset mid-frame, then a clean 8'hA5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("midrst_lanes", 32'(out_lanes), 32'h0);
    chk("midrst_sel",   32'(sel),       32'h0);
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_ready", 32'(in_ready),  32'h1);
    send_frame(8'hA5, 1'b0, 1'b1);
    chk("a5_word",  32'(out_lanes), 32'hA5);
    chk("a5_valid", 32'(out_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // test 6: idle cycle between every bit
    send_frame(8'h3C, 1'b1, 1'b1);
    chk("gap_word",  32'(out_lanes), 32'h3C);
    chk("gap_valid", 32'(out_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 199) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
